// File: rtl/srl_bus_deser_if.sv
// ---------------------------------------------------------------------------
// srl_bus_deser_if : serial-in / word-out bus bundle for the SRL deserialiser
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface srl_bus_deser_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 ser_data;
  logic                 ser_valid;
  logic                 ser_start;
  logic [BUS_WIDTH-1:0] data_output;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overrun;
  logic                 frame_err;
  logic                 clr_err;

  modport master (
    output ser_data, ser_valid, ser_start, out_ready, clr_err,
    input  data_output, out_valid, overrun, frame_err
  );

  modport slave (
    input  ser_data, ser_valid, ser_start, out_ready, clr_err,
    output data_output, out_valid, overrun, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/srl_bus_deser.sv
// ---------------------------------------------------------------------------
// srl_bus_deser : framed serial-to-parallel receiver with one-word buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module srl_bus_deser #(
  parameter int BUS_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  srl_bus_deser_if.slave bus
);

  localparam int            CW     = $clog2(BUS_WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BUS_WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BUS_WIDTH-1:0] shreg_q;
  logic [BUS_WIDTH-1:0] shreg_d;
  logic [BUS_WIDTH-1:0] shbase;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic                 ovr_q;
  logic                 ferr_q;

  logic in_shift;
  logic complete;
  logic load;
  logic ferr_ev;
  logic ovr_ev;

  // A start bit always begins from an empty register so a restart leaves no residue.
  assign shbase = bus.ser_start ? '0 : shreg_q;

  if (MSB_FIRST) begin : g_msb_first
    assign shreg_d = {shbase[BUS_WIDTH-2:0], bus.ser_data};
  end else begin : g_lsb_first
    assign shreg_d = {bus.ser_data, shbase[BUS_WIDTH-1:1]};
  end

  always_comb begin
    in_shift = (state_q == S_SHIFT);
    complete = bus.ser_valid & ~bus.ser_start & in_shift & (cnt_q == C_LAST);
    load     = complete & (~valid_q | bus.out_ready);
    ovr_ev   = complete & valid_q & ~bus.out_ready;
    ferr_ev  = bus.ser_valid & ((~in_shift & ~bus.ser_start) | (in_shift & bus.ser_start));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (bus.ser_valid) begin
        if (bus.ser_start) begin
          shreg_q <= shreg_d;
          cnt_q   <= C_ONE;
          state_q <= S_SHIFT;
        end else if (in_shift) begin
          shreg_q <= shreg_d;
          if (cnt_q == C_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
      end

      if (load) begin
        data_q  <= shreg_d;
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end

      // Clear first so a simultaneous new event keeps the flag set.
      if (bus.clr_err) begin
        ovr_q  <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (ovr_ev) begin
        ovr_q <= 1'b1;
      end
      if (ferr_ev) begin
        ferr_q <= 1'b1;
      end
    end
  end

  assign bus.data_output = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.overrun     = ovr_q;
  assign bus.frame_err   = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_srl_bus_deser.sv
// ---------------------------------------------------------------------------
// tb_srl_bus_deser : MSB- and LSB-first receivers against a frame-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_srl_bus_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_data = 1'b0;
  logic ser_valid = 1'b0;
  logic ser_start = 1'b0;
  logic out_ready = 1'b1;
  logic clr_err = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  srl_bus_deser_if #(.BUS_WIDTH(W)) ifm ();
  srl_bus_deser_if #(.BUS_WIDTH(W)) ifl ();

  assign ifm.ser_data  = ser_data;
  assign ifm.ser_valid = ser_valid;
  assign ifm.ser_start = ser_start;
  assign ifm.out_ready = out_ready;
  assign ifm.clr_err   = clr_err;
  assign ifl.ser_data  = ser_data;
  assign ifl.ser_valid = ser_valid;
  assign ifl.ser_start = ser_start;
  assign ifl.out_ready = out_ready;
  assign ifl.clr_err   = clr_err;

  srl_bus_deser #(.BUS_WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (.clk(clk), .rst(rst), .bus(ifm.slave));
  srl_bus_deser #(.BUS_WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (.clk(clk), .rst(rst), .bus(ifl.slave));

  // Frame-level model: list of bits received so far in the open frame.
  bit         q[$];
  bit         in_frame;
  bit         mv;
  logic [W-1:0] mdm, mdl;
  bit         movr, mferr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_update();
    bit cmp, ferr_ev, ovr_ev;
    logic [W-1:0] wm, wl;
    cmp = 0; ferr_ev = 0; wm = '0; wl = '0;
    if (rst) begin
      q.delete(); in_frame = 0; mv = 0; mdm = '0; mdl = '0; movr = 0; mferr = 0;
    end else begin
      if (ser_valid) begin
        if (ser_start) begin
          if (in_frame) ferr_ev = 1;
          q.delete();
          q.push_back(ser_data);
          in_frame = 1;
        end else if (!in_frame) begin
          ferr_ev = 1;
        end else begin
          q.push_back(ser_data);
          if (q.size() == W) begin
            cmp = 1;
            for (int i = 0; i < W; i++) begin
              wm[W-1-i] = q[i];
              wl[i]     = q[i];
            end
            q.delete();
            in_frame = 0;
          end
        end
      end
      ovr_ev = cmp && mv && !out_ready;
      if (cmp && (!mv || out_ready)) begin
        mv = 1; mdm = wm; mdl = wl;
      end else if (mv && out_ready) begin
        mv = 0;
      end
      mferr = ferr_ev ? 1'b1 : (clr_err ? 1'b0 : mferr);
      movr  = ovr_ev  ? 1'b1 : (clr_err ? 1'b0 : movr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("valid_msb", 32'(ifm.out_valid), 32'(mv));
    chk("valid_lsb", 32'(ifl.out_valid), 32'(mv));
    chk("data_msb",  32'(ifm.data_output), 32'(mdm));
    chk("data_lsb",  32'(ifl.data_output), 32'(mdl));
    chk("ovr_msb",   32'(ifm.overrun), 32'(movr));
    chk("ovr_lsb",   32'(ifl.overrun), 32'(movr));
    chk("ferr_msb",  32'(ifm.frame_err), 32'(mferr));
    chk("ferr_lsb",  32'(ifl.frame_err), 32'(mferr));
  endtask

  task automatic idle(input int n);
    ser_valid = 0; ser_start = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Sends w[W-1] first; optional random gaps; optional out_ready pulse on the last bit.
  task automatic send_bits(input logic [W-1:0] w, input int nbits, input int gapmax, input bit rdy_last);
    for (int i = 0; i < nbits; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      ser_valid = 0; ser_start = 0;
      for (int k = 0; k < g; k++) step();
      ser_valid = 1;
      ser_start = (i == 0);
      ser_data  = w[W-1-i];
      if (rdy_last && i == nbits - 1) out_ready = 1;
      step();
      if (rdy_last && i == nbits - 1) out_ready = 0;
    end
    ser_valid = 0; ser_start = 0;
  endtask

  initial begin
    rst = 1;
    step();
    chk("rst_valid", 32'(ifm.out_valid), 32'd0);
    chk("rst_data",  32'(ifm.data_output), 32'd0);
    rst = 0;
    idle(2);

    out_ready = 1;
    send_bits(8'hA5, W, 0, 0);
    chk("a5_valid", 32'(ifm.out_valid), 32'd1);
    chk("a5_msb",   32'(ifm.data_output), 32'hA5);
    chk("a5_lsb",   32'(ifl.data_output), 32'hA5);
    idle(1);
    chk("a5_pulse", 32'(ifm.out_valid), 32'd0);
    chk("a5_flags", 32'({ifm.overrun, ifm.frame_err}), 32'd0);

    send_bits(8'hC0, W, 0, 0);
    chk("c0_msb", 32'(ifm.data_output), 32'hC0);
    chk("c0_lsb", 32'(ifl.data_output), 32'h03);
    idle(1);

    out_ready = 0;
    send_bits(8'h3C, W, 3, 0);
    idle(3);
    chk("bp_valid", 32'(ifm.out_valid), 32'd1);
    chk("bp_data",  32'(ifm.data_output), 32'h3C);
    out_ready = 1; step(); out_ready = 0;
    step();
    chk("bp_drain", 32'(ifm.out_valid), 32'd0);

    send_bits(8'h11, W, 0, 0);
    send_bits(8'h22, W, 0, 0);
    chk("ovr_data", 32'(ifm.data_output), 32'h11);
    chk("ovr_flag", 32'(ifm.overrun), 32'd1);
    clr_err = 1; step(); clr_err = 0;
    chk("ovr_clr", 32'(ifm.overrun), 32'd0);
    send_bits(8'h22, W, 0, 1);
    chk("ovr_ok_data", 32'(ifm.data_output), 32'h22);
    chk("ovr_ok_flag", 32'(ifm.overrun), 32'd0);
    out_ready = 1; idle(1);

    send_bits(8'hFF, 4, 0, 0);
    send_bits(8'hF0, W, 0, 0);
    chk("fr_ferr", 32'(ifm.frame_err), 32'd1);
    chk("fr_data", 32'(ifm.data_output), 32'hF0);
    clr_err = 1; idle(1); clr_err = 0;
    ser_valid = 1; ser_start = 0; ser_data = 1; step();
    ser_valid = 0; step();
    chk("stray_ferr",  32'(ifm.frame_err), 32'd1);
    chk("stray_valid", 32'(ifm.out_valid), 32'd0);

    send_bits(8'hFF, 5, 0, 0);
    rst = 1; step(); rst = 0;
    chk("mr_outs", 32'({ifm.data_output, ifm.out_valid, ifm.overrun, ifm.frame_err}), 32'd0);
    send_bits(8'h5A, W, 0, 0);
    chk("mr_data", 32'(ifm.data_output), 32'h5A);
    chk("mr_ferr", 32'(ifm.frame_err), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      ser_valid = ($urandom_range(9, 0) < 7);
      ser_start = ($urandom_range(11, 0) == 0);
      ser_data  = 1'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      clr_err   = ($urandom_range(19, 0) == 0);
      rst       = ($urandom_range(199, 0) == 0);
      step();
    end
    rst = 0; clr_err = 0; ser_valid = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/srl_bus_deser.md
Name: srl_bus_deser

Overview:
- Serial-to-parallel receiver for the SRL bus datapath.
- Collects a framed single-bit stream into BUS_WIDTH-bit words and presents each word on a registered output with a valid/ready handshake.
- A one-word output buffer decouples the serial side from the downstream consumer.
- Overrun and framing errors are flagged with sticky status bits.

Parameters:
- BUS_WIDTH, 8, output word width in bits; legal values are 2 and above.
- MSB_FIRST, 1, bit order. 1: the first received bit lands in data_output[BUS_WIDTH-1]. 0: the first received bit lands in data_output[0].

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ser_data  in  1  serial data bit.
- ser_valid  in  1  ser_data is valid this cycle.
- ser_start  in  1  first bit of a frame; qualified by ser_valid.
- data_output  out  BUS_WIDTH  assembled word, registered.
- out_valid  out  1  data_output holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- overrun  out  1  sticky: a completed word was dropped.
- frame_err  out  1  sticky: a frame was restarted or a bit arrived outside a frame.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; bit counter and shift register go to 0.
  - data_output=0, out_valid=0, overrun=0, frame_err=0.
  - Reset mid-frame discards the partial word. Reset while out_valid=1 discards the buffered word.
- Bit counter width is $clog2(BUS_WIDTH+1). Shift register is BUS_WIDTH bits, separate from the output buffer.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit BUS_WIDTH-1.
- FSM state IDLE:
  - ser_valid & ser_start: shift the bit in, count=1, go to SHIFT.
  - ser_valid & !ser_start: bit ignored, frame_err set.
  - ser_valid=0: no change.
- FSM state SHIFT:
  - ser_valid & !ser_start: shift the bit in, count+1.
  - ser_valid & ser_start: premature restart. frame_err set, partial word discarded, this bit becomes bit 1 of a new frame, count=1.
  - ser_valid=0: hold; gaps of any length are allowed.
- Word completion happens at the edge that samples bit number BUS_WIDTH:
  - The word goes to the output buffer per the rules below. The FSM returns to IDLE and count=0.
  - The next frame requires a new ser_start. That start may come in the cycle immediately after completion.
- Output buffer:
  - Load when completing and (out_valid=0, or out_valid & out_ready in the same cycle). data_output is updated and out_valid=1 from the next cycle.
  - Latency: out_valid rises in the cycle after the last bit's sampling edge.
  - If completing while out_valid=1 & out_ready=0, the new word is dropped, overrun is set, and data_output/out_valid are unchanged.
  - Accept without completion: out_valid goes to 0 next cycle. data_output holds its last value.
  - data_output is stable while out_valid=1 and out_ready=0.
- Sticky flags:
  - Set and hold until clr_err=1 or rst.
  - If clr_err and a new error event occur in the same cycle, the flag stays set (set wins).
- Throughput: one word per BUS_WIDTH valid cycles. With out_ready tied high, back-to-back frames never overrun.

Test Plan:
- Basic MSB_FIRST=1, BUS_WIDTH=8: send 1,0,1,0,0,1,0,1 on consecutive cycles, ser_start on the first, out_ready=1 → data_output=8'hA5 with a one-cycle out_valid pulse one cycle after the 8th bit. overrun=0, frame_err=0.
- MSB_FIRST=0: same bit sequence → data_output=8'hA5 bit-reversed = 8'hA5. Repeat with bits 1,1,0,0,0,0,0,0 → 8'h03 for MSB_FIRST=0 and 8'hC0 for MSB_FIRST=1.
- Gaps and backpressure: hold out_ready=0 and send 8'h3C with random ser_valid gaps → out_valid=1 and data_output=8'h3C held stable. Raise out_ready for 1 cycle → out_valid=0 next cycle.
- Overrun: with out_ready=0, send 8'h11 then 8'h22 → data_output stays 8'h11 and overrun=1. Pulse clr_err → overrun=0. Repeat with out_ready=1 in the completion cycle of 8'h22 → data_output=8'h22, overrun=0.
- Framing: assert ser_start again after 4 bits, then send 8 bits of 8'hF0 → frame_err=1, data_output=8'hF0. Send one stray bit in IDLE without ser_start → frame_err=1, no word produced.
- Reset mid-operation: assert rst after 5 bits of a frame → all outputs 0. The next full frame 8'h5A completes correctly with no residue from the aborted frame.
